// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity encodings and index widths.
// Used by the tx block and its rx counterpart.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int IDX_W = 4;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..div-1 while enabled and flags the last two counts.
// bit_pre marks the second-to-last clock of a bit so a frame can hand over one clock early.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] div,
    input  logic             enable,
    input  logic             clear,
    output logic             bit_end,
    output logic             bit_pre
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign bit_end = enable && (cnt_q == div - DIV_W'(1));
    assign bit_pre = enable && (cnt_q == div - DIV_W'(2));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready intake and runtime baud divisor.
// The final stop clock doubles as the first idle cycle, so back-to-back frames have no gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_cfg: illegal DATA_BITS/PARITY/STOP_BITS");
    end

    localparam bit HAS_PAR = (PARITY != PAR_NONE);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 bit_end;
    logic                 bit_pre;
    logic                 last_stop;

    assign accept    = tx_valid && (state_q == ST_IDLE);
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .div    (div_q),
        .enable (state_q != ST_IDLE),
        .clear  (state_d == ST_IDLE),
        .bit_end(bit_end),
        .bit_pre(bit_pre)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        div_d      = div_q;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    shift_d = tx_data;
                    par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                    div_d   = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                bit_idx_d = bit_idx_q;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                stop_idx_d = stop_idx_q;
                // Leave one clock early: the idle cycle completes the last stop bit.
                if (last_stop && bit_pre) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    stop_idx_d = stop_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        unique case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            div_q      <= DIV_W'(2);
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = !tx_ready;

endmodule
